// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and helpers for the buffered UART transmitter.
package uart_tx_fifo_pkg;

    // Default line settings, common to the transmitter and the receiver on the same link.
    localparam int unsigned UartClkFreq = 25000000;
    localparam int unsigned UartBaud    = 115200;

    // Widest frame: start + 8 data + 2 stop.
    localparam int unsigned FrameBits = 11;

    // Number of bit periods in one frame for the given stop-bit count.
    function automatic logic [3:0] frame_len(input int unsigned stop_bits);
        return (stop_bits == 2) ? 4'd11 : 4'd10;
    endfunction

    // Shift-register image of a frame, LSB leaves first. Both stop bits are always present;
    // with one stop bit the frame length simply ends the frame before the second one.
    function automatic logic [FrameBits-1:0] frame_image(input logic [7:0] data);
        return {2'b11, data, 1'b0};
    endfunction

endpackage

// File: rtl/tx_fifo_sync.sv
// DEPTH x 8 register-file FIFO with combinational head output and an explicit occupancy counter.
module tx_fifo_sync #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      resetq,
    input  logic                      push,
    input  logic                      pop,
    input  logic [7:0]                din,
    output logic [7:0]                dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full  = (level_q == FullLevel);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for pointers (wrap modulo DEPTH) and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Data storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: byte FIFO drained back-to-back by a serial shifter.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKFREQ   = UartClkFreq,
    parameter int unsigned BAUD      = UartBaud,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      resetq,
    input  logic                      wr,
    input  logic [7:0]                tx_data,
    input  logic                      clr_ovf,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      busy,
    output logic                      ovf,
    output logic                      tx
);

    localparam int unsigned Bp = CLKFREQ / BAUD;
    localparam int unsigned BW = $clog2(Bp);
    localparam logic [BW-1:0] BaudMax = BW'(Bp - 1);
    localparam logic [3:0] FrameLen = frame_len(STOP_BITS);

    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [FrameBits-1:0] shreg_q, shreg_d;
    logic                 tx_q;
    logic                 ovf_q, ovf_d;

    logic       idle, bit_end, last_bit, load;
    logic [7:0] head;
    logic       fifo_full, fifo_empty;

    tx_fifo_sync #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (wr),
        .pop    (load),
        .din    (tx_data),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign idle     = (bitcnt_q == 4'd0);
    assign bit_end  = ~idle & (baud_q == BaudMax);
    assign last_bit = bit_end & (bitcnt_q == 4'd1);
    // Loading on the final stop-bit edge is what makes frames leave with no idle gap.
    assign load     = (idle | last_bit) & ~fifo_empty;

    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign busy  = ~fifo_empty | ~idle;
    assign ovf   = ovf_q;
    assign tx    = tx_q;

    // Baud counter, bit counter and shift register next-state.
    always_comb begin
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        if (load) begin
            baud_d   = '0;
            bitcnt_d = FrameLen;
            shreg_d  = frame_image(head);
        end else if (bit_end) begin
            baud_d   = '0;
            bitcnt_d = bitcnt_q - 4'd1;
            shreg_d  = {1'b1, shreg_q[FrameBits-1:1]};
        end else if (!idle) begin
            baud_d   = baud_q + BW'(1);
        end
    end

    // Sticky overflow; a fresh overflow wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr && fifo_full) ovf_d = 1'b1;
        else if (clr_ovf)    ovf_d = 1'b0;
    end

    // Shifter state, registered tx pin and overflow flag.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            baud_q   <= '0;
            bitcnt_q <= 4'd0;
            shreg_q  <= '1;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            // tx follows the shifter one cycle later, so it changes only on clean edges.
            tx_q     <= shreg_q[0];
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven FIFO/overflow vectors plus frame sequences.
module tb_uart_tx_fifo;

    localparam int unsigned BP    = 217;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned F1    = 10 * BP;   // 8N1 frame
    localparam int unsigned F2    = 11 * BP;   // 8N2 frame

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       wr = 1'b0, clr_ovf = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       full, empty, busy, ovf, tx;
    logic [4:0] level;

    logic       wr2 = 1'b0, clr_ovf2 = 1'b0;
    logic [7:0] tx_data2 = 8'h00;
    logic       full2, empty2, busy2, ovf2, tx2;
    logic [4:0] level2;

    uart_tx_fifo #(
        .CLKFREQ   (25000000),
        .BAUD      (115200),
        .DEPTH     (DEPTH),
        .STOP_BITS (1)
    ) dut (
        .clk     (clk),
        .resetq  (resetq),
        .wr      (wr),
        .tx_data (tx_data),
        .clr_ovf (clr_ovf),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .busy    (busy),
        .ovf     (ovf),
        .tx      (tx)
    );

    uart_tx_fifo #(
        .CLKFREQ   (25000000),
        .BAUD      (115200),
        .DEPTH     (DEPTH),
        .STOP_BITS (2)
    ) dut2 (
        .clk     (clk),
        .resetq  (resetq),
        .wr      (wr2),
        .tx_data (tx_data2),
        .clr_ovf (clr_ovf2),
        .full    (full2),
        .empty   (empty2),
        .level   (level2),
        .busy    (busy2),
        .ovf     (ovf2),
        .tx      (tx2)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // tx / busy edge recorder, sampled on the falling clock edge.
    int unsigned e1[$];
    int unsigned e2[$];
    int unsigned busy_fall1 = 0, busy_fall2 = 0;
    logic tx_prev = 1'b1, tx2_prev = 1'b1, busy_prev = 1'b0, busy2_prev = 1'b0;

    always @(negedge clk) begin
        if (tx !== tx_prev)   e1.push_back(cyc);
        if (tx2 !== tx2_prev) e2.push_back(cyc);
        if (busy_prev === 1'b1 && busy === 1'b0)   busy_fall1 = cyc;
        if (busy2_prev === 1'b1 && busy2 === 1'b0) busy_fall2 = cyc;
        tx_prev    = tx;
        tx2_prev   = tx2;
        busy_prev  = busy;
        busy2_prev = busy2;
    end

    // Serial receiver model for the 8N1 instance: mid-bit sampling, frames cut by reset dropped.
    logic [7:0]  rx_q[$];
    int unsigned rx_starts[$];
    logic        rst_seen = 1'b0;

    always @(negedge resetq) rst_seen = 1'b1;

    initial begin : rx_decoder
        logic [7:0]  b;
        logic        ok;
        int unsigned t0;
        forever begin
            @(negedge clk);
            if (resetq === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                rst_seen = 1'b0;
                repeat (BP / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BP) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BP) @(negedge clk);
                ok = ok & (tx === 1'b1);
                if (!rst_seen) begin
                    check("rx framing", {31'd0, ok}, 32'd1);
                    rx_q.push_back(b);
                    rx_starts.push_back(t0);
                end
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycle %0d, want completion before 95000", cyc);
        $fatal(1, "watchdog");
    end

    int unsigned last_edge;

    // Drive one write; it is taken at the next rising edge (recorded in last_edge).
    task automatic push(input logic [7:0] d);
        wr = 1'b1;
        tx_data = d;
        last_edge = cyc + 1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic push2(input logic [7:0] d);
        wr2 = 1'b1;
        tx_data2 = d;
        last_edge = cyc + 1;
        @(negedge clk);
        wr2 = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int sel, input int unsigned limit, input string name);
        int unsigned n = 0;
        while (((sel == 0) ? busy : busy2) !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " drain"}, {31'd0, (sel == 0) ? busy : busy2}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic       clr;
        logic [7:0] data;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t tbl[20];
    logic [7:0] exp_bytes[$];

    initial begin
        int unsigned n0, l0, t0, sz_e, sz_rx;
        logic [7:0] d;

        // FIFO fill / overflow vectors, applied while the shifter holds one frame.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(8'hB0 + i), 5'(i + 1), (i == 15), 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'hEE, 5'd16, 1'b1, 1'b0, 1'b1};  // write while full
        tbl[17] = '{1'b1, 1'b1, 8'hEF, 5'd16, 1'b1, 1'b0, 1'b1};  // overflow beats clear
        tbl[18] = '{1'b0, 1'b1, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};  // clear
        tbl[19] = '{1'b0, 1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 1);
        check("reset level", {27'd0, level}, 0);
        check("reset empty", {31'd0, empty}, 1);
        check("reset full", {31'd0, full}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset ovf", {31'd0, ovf}, 0);
        check("reset tx2", {31'd0, tx2}, 1);
        resetq = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single 0x55 frame, exact bit timing
        e1.delete();
        rx_q.delete();
        push(8'h55);
        n0 = last_edge;
        wait_idle(0, 3000, "t1");
        t0 = (e1.size() > 0) ? e1[0] : 0;
        check("t1 edge count", e1.size(), 10);
        check("t1 first fall", t0, n0 + 2);
        for (int k = 1; k < 10; k++)
            check($sformatf("t1 edge%0d", k), (k < e1.size()) ? e1[k] - t0 : 0, k * BP);
        // busy falls with the shifter, which runs one cycle ahead of the tx register.
        check("t1 busy fall", busy_fall1, n0 + 1 + F1);
        check("t1 rx count", rx_q.size(), 1);
        check("t1 rx byte", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'h55);

        // 2: three consecutive writes, back-to-back frames
        rx_q.delete();
        rx_starts.delete();
        push(8'h41);
        n0 = last_edge;
        push(8'h42);
        push(8'h43);
        l0 = n0 + 1;  // first pop; the second write lands in the same cycle
        check("t2 level after writes", {27'd0, level}, 2);
        wait_cyc(l0 + F1 - 1);
        check("t2 level before 2nd load", {27'd0, level}, 2);
        wait_cyc(l0 + F1);
        check("t2 level 2nd load", {27'd0, level}, 1);
        wait_cyc(l0 + 2 * F1);
        check("t2 level 3rd load", {27'd0, level}, 0);
        check("t2 busy mid", {31'd0, busy}, 1);
        wait_idle(0, 5000, "t2");
        check("t2 busy fall", busy_fall1, l0 + 3 * F1);
        check("t2 rx count", rx_q.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("t2 rx byte%0d", k), (k < rx_q.size()) ? rx_q[k] : 8'h00, 8'h41 + k);
        for (int k = 1; k < 3; k++)
            check($sformatf("t2 gap%0d", k),
                  (k < rx_starts.size()) ? rx_starts[k] - rx_starts[k-1] : 0, F1);

        // 3: fill to full and overflow while frame 1 is on the wire
        rx_q.delete();
        push(8'hA0);
        @(negedge clk);
        check("t3 level after load", {27'd0, level}, 0);
        for (int i = 0; i < 20; i++) begin
            wr = tbl[i].wr;
            clr_ovf = tbl[i].clr;
            tx_data = tbl[i].data;
            @(negedge clk);
            check($sformatf("t3 row%0d level", i), {27'd0, level}, {27'd0, tbl[i].lvl});
            check($sformatf("t3 row%0d full", i), {31'd0, full}, {31'd0, tbl[i].full});
            check($sformatf("t3 row%0d empty", i), {31'd0, empty}, {31'd0, tbl[i].empty});
            check($sformatf("t3 row%0d ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
            check($sformatf("t3 row%0d busy", i), {31'd0, busy}, 1);
        end
        wr = 1'b0;
        clr_ovf = 1'b0;
        wait_idle(0, 17 * F1 + 500, "t3");
        check("t3 rx count", rx_q.size(), 17);
        check("t3 rx byte0", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'hA0);
        for (int k = 1; k < 17; k++)
            check($sformatf("t3 rx byte%0d", k), (k < rx_q.size()) ? rx_q[k] : 8'h00,
                  8'hB0 + k - 1);

        // 4: asynchronous reset in the middle of a frame with five bytes queued
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            push(8'(8'hC0 + i));
            if (i == 0) n0 = last_edge;
        end
        check("t4 level queued", {27'd0, level}, 5);
        wait_cyc(n0 + 1 + 4 * BP + BP / 2);
        #2 resetq = 1'b0;
        #1;
        check("t4 rst tx", {31'd0, tx}, 1);
        check("t4 rst level", {27'd0, level}, 0);
        check("t4 rst busy", {31'd0, busy}, 0);
        check("t4 rst empty", {31'd0, empty}, 1);
        @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        sz_e = e1.size();
        sz_rx = rx_q.size();
        repeat (2 * F1) @(negedge clk);
        check("t4 no tx edges", e1.size(), sz_e);
        check("t4 no frames", rx_q.size(), sz_rx);
        check("t4 tx idle", {31'd0, tx}, 1);
        check("t4 busy idle", {31'd0, busy}, 0);

        // 5: two stop bits, 0xFF then 0x00
        e2.delete();
        push2(8'hFF);
        n0 = last_edge;
        push2(8'h00);
        wait_idle(1, 6000, "t5");
        t0 = (e2.size() > 0) ? e2[0] : 0;
        check("t5 edge count", e2.size(), 4);
        check("t5 first fall", t0, n0 + 2);
        check("t5 start1 width", (e2.size() > 1) ? e2[1] - t0 : 0, BP);
        check("t5 frame length", (e2.size() > 2) ? e2[2] - t0 : 0, F2);
        check("t5 data2 width", (e2.size() > 3) ? e2[3] - e2[2] : 0, 9 * BP);
        check("t5 busy fall", busy_fall2, n0 + 1 + 2 * F2);
        check("t5 tx2 idle", {31'd0, tx2}, 1);

        // 6: random bytes through the line model, order and count preserved
        rx_q.delete();
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_bytes.push_back(d);
            push(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0, 9 * F1, "t6");
        check("t6 rx count", rx_q.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t6 rx byte%0d", k), (k < rx_q.size()) ? rx_q[k] : 8'h00,
                  exp_bytes[k]);
        check("t6 ovf", {31'd0, ovf}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
